fu_issue_queue: RTL
===================

# fu_issue_queue

Parametrised issue queue that sits between the dual-dispatch stage and any multi-cycle functional unit (MDU, divider, future FPU). It is the successor to the fixed 8-entry in-order MDU queue. It generalises depth, dispatch width and operand count, and adds a selectable out-of-order "oldest-ready" issue mode. Entries capture source operands from the CDB while waiting, and issue through a registered valid/ready stage into the unit.

## Interface
- `DEPTH`, 8: number of slots, ≥ `DISP_W`.
- `DISP_W`, 2: dispatch lanes per cycle.
- `REG_COUNT`, 2: source operands per instruction.
- `CDB_COUNT`, 2: CDB broadcast ports.
- `PAYLOAD_W`, 64: opaque per-instruction payload width (op, wreg id, exception info).
- `OOO_ISSUE`, 0: 0 issues the oldest entry only; 1 issues the oldest entry whose operands are all ready.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous pipeline flush.
- `disp_valid_i` input `DISP_W`: per-lane dispatch request. Any mask is allowed.
- `disp_payload_i` input `DISP_W`×`PAYLOAD_W`: payload per lane.
- `disp_data_i` input `DISP_W`×`REG_COUNT`×word_t: operand values.
- `disp_tag_i` input `DISP_W`×`REG_COUNT`×rob_id_t: producer tags.
- `disp_rdy_i` input `DISP_W`×`REG_COUNT`: operand already valid.
- `disp_ready_o` output 1: registered; at least `DISP_W` slots free.
- `cdb_valid_i` input `CDB_COUNT`: broadcast valid.
- `cdb_tag_i` input `CDB_COUNT`×rob_id_t: broadcast tags.
- `cdb_data_i` input `CDB_COUNT`×word_t: broadcast data.
- `iss_valid_o` output 1: issue register holds an instruction.
- `iss_ready_i` input 1: the functional unit accepts the instruction.
- `iss_payload_o` output `PAYLOAD_W`: issued payload.
- `iss_data_o` output `REG_COUNT`×word_t: issued operands.
- `occupancy_o` output `$clog2(DEPTH)+1`: occupied slot count, registered.

## Operation
- Slots are allocated from a free mask. Valid lanes are written, in lane order, into the lowest-indexed free slots. The write is accepted only when `disp_ready_o`=1. Lanes presented while `disp_ready_o`=0 are dropped silently; this is the caller's error.
- Age is tracked by an age matrix: `older[i][j]`=1 means slot i was written before slot j.
  - Lanes written in the same cycle are ordered lane 0 oldest.
  - A new slot is younger than every occupied slot.
- Operand capture, per slot and per operand:
  - If the operand is not ready and a CDB port with valid=1 matches its tag, the slot latches the data and sets ready.
  - Capture also applies to incoming dispatch lanes in the dispatch cycle: a CDB match at dispatch gives a ready operand at write.
  - If several CDB ports match, the lowest-index port wins.
- Selection, evaluated every cycle:
  - `OOO_ISSUE`=0: the oldest occupied slot is a candidate only if all its operands are ready.
  - `OOO_ISSUE`=1: the candidate is the oldest slot with all operands ready.
- Issue fires when a candidate exists and the issue register is empty or `iss_ready_i`=1. Firing frees the slot and loads the issue register in the same edge.
- `iss_valid_o` clears on an accepted handshake with no new candidate. Payload and data hold stable while `iss_valid_o`=1 and `iss_ready_i`=0.
- Free count is updated as free_next = free − accepted lanes + fired.
- `disp_ready_o` is registered: it is set when free_next ≥ `DISP_W`.
- Flush clears all slots, the age matrix and the issue register. Dispatch and CDB activity in the flush cycle are ignored.

## Timing
- Reset and post-flush values:
  - `disp_ready_o`=1
  - `occupancy_o`=0
  - `iss_valid_o`=0
  - `iss_payload_o`=0 and `iss_data_o`=0
  - all slots invalid
- Dispatch at cycle t with operands ready: the slot is occupied at t+1, selected at t+1, and `iss_valid_o`=1 at t+2.
- CDB capture at cycle t: the operand is ready at t+1, and the earliest `iss_valid_o` is at t+2.
- Back-to-back issue, one per cycle, is sustained while `iss_ready_i`=1.
- A slot freed at cycle t may be reallocated by dispatch at t+1. `disp_ready_o` reflects the free count one cycle late, which is conservative.
- Full queue with a simultaneous issue: the freed slot is counted in the next `disp_ready_o`.
- Flush and an issue handshake in the same cycle: flush wins, and `iss_valid_o`=0 next cycle.
- Asynchronous reset mid-operation clears state immediately, regardless of `clk`.

## Structure
- The shared package `iq_pkg` holds:
  - the slot struct: valid, payload, data[REG_COUNT], tag[REG_COUNT], rdy[REG_COUNT];
  - a `cdb_match` function (tag compare and priority select).
  - `word_t` and `rob_id_t` come from the existing global defines.
- One sub-module, `iq_slot`: a single entry with its capture logic, instantiated `DEPTH` times.
- The age matrix, allocator, selector and issue register live at top level.

## Test plan
- In-order mode, DEPTH=4:
  - Dispatch A (not ready, tag 5), then B (ready).
  - Expect B not to issue.
  - CDB tag 5 with data 0x11 at cycle 10 → A issues with `iss_data_o`[0]=0x11 at cycle 12, and B issues at cycle 13.
- OOO mode, same stimulus → B issues first, at dispatch+2; A issues after the CDB at cycle 12.
- Fill to `DEPTH`, with `iss_ready_i`=0.
  - Expect `disp_ready_o`=0 once free < `DISP_W`.
  - Expect `occupancy_o`=DEPTH−1, because the issue register holds one instruction.
  - Raise `iss_ready_i` → `disp_ready_o` returns to 1 within 2 cycles.
- CDB match in the same cycle as dispatch of a not-ready operand → the entry issues at t+2 with the CDB data.
- Flush with 3 occupied slots and `iss_valid_o`=1 → next cycle `occupancy_o`=0, `iss_valid_o`=0, `disp_ready_o`=1; a dispatch issued during the flush cycle never issues.
- Assert `rst_n`=0 asynchronously between edges mid-stream → outputs take reset values immediately; after release, a new dispatch issues normally at t+2.

Source files
------------

// File: rtl/iq_pkg.sv
// iq_pkg
//   Shared types for fu_issue_queue and iq_slot.
//   - word_t / rob_id_t : operand word and producer tag (global machine widths)
//   - IQ_*              : operand count, payload width and CDB port count that
//                         size the slot struct; the queue's matching parameters
//                         default to these and must be kept equal to them
//   - iq_slot_t         : architectural contents of one queue entry
//   - cdb_match         : tag compare across all CDB ports, lowest port wins
package iq_pkg;

    localparam int WORD_W   = 32;
    localparam int ROB_ID_W = 6;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;

    localparam int IQ_REG_COUNT = 2;
    localparam int IQ_PAYLOAD_W = 64;
    localparam int IQ_CDB_COUNT = 2;

    typedef struct packed {
        logic                          valid;
        logic [IQ_PAYLOAD_W-1:0]       payload;
        word_t   [IQ_REG_COUNT-1:0]    data;
        rob_id_t [IQ_REG_COUNT-1:0]    tag;
        logic    [IQ_REG_COUNT-1:0]    rdy;
    } iq_slot_t;

    typedef struct packed {
        logic  hit;
        word_t data;
    } cdb_hit_t;

    // Walk from the highest port down so the lowest matching port is the
    // last one written and therefore wins.
    function automatic cdb_hit_t cdb_match(
        input rob_id_t                     tag,
        input logic    [IQ_CDB_COUNT-1:0]  cdb_valid,
        input rob_id_t [IQ_CDB_COUNT-1:0]  cdb_tag,
        input word_t   [IQ_CDB_COUNT-1:0]  cdb_data
    );
        cdb_hit_t res;
        res = '0;
        for (int p = IQ_CDB_COUNT - 1; p >= 0; p--) begin
            if (cdb_valid[p] && (cdb_tag[p] == tag)) begin
                res.hit  = 1'b1;
                res.data = cdb_data[p];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/iq_slot.sv
// iq_slot
//   One issue-queue entry. Holds payload, operands, tags and ready bits and
//   snoops the CDB for any operand still waiting. Capture also applies to the
//   entry being written this cycle, so a broadcast that coincides with
//   dispatch is not missed.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     flush        synchronous clear of the entry
//     wr_en        load wr_slot (only asserted when the entry is free)
//     clr          entry has been issued; drop it
//     wr_slot      incoming entry contents from the dispatch lane
//     cdb_*_i      CDB broadcast ports
//     valid_o      entry occupied
//     payload_o    stored payload
//     data_o       stored operand values
//     all_rdy_o    entry occupied and every operand ready
module iq_slot
    import iq_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             wr_en,
    input  logic                             clr,
    input  iq_slot_t                         wr_slot,
    input  logic    [IQ_CDB_COUNT-1:0]       cdb_valid_i,
    input  rob_id_t [IQ_CDB_COUNT-1:0]       cdb_tag_i,
    input  word_t   [IQ_CDB_COUNT-1:0]       cdb_data_i,
    output logic                             valid_o,
    output logic    [IQ_PAYLOAD_W-1:0]       payload_o,
    output word_t   [IQ_REG_COUNT-1:0]       data_o,
    output logic                             all_rdy_o
);

    iq_slot_t slot_q;
    iq_slot_t slot_d;
    cdb_hit_t hit;

    always_comb begin
        slot_d = slot_q;
        hit    = '0;
        if (wr_en) begin
            slot_d = wr_slot;
        end else if (clr) begin
            slot_d.valid = 1'b0;
        end
        for (int r = 0; r < IQ_REG_COUNT; r++) begin
            hit = cdb_match(slot_d.tag[r], cdb_valid_i, cdb_tag_i, cdb_data_i);
            if (slot_d.valid && !slot_d.rdy[r] && hit.hit) begin
                slot_d.data[r] = hit.data;
                slot_d.rdy[r]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (flush) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign valid_o   = slot_q.valid;
    assign payload_o = slot_q.payload;
    assign data_o    = slot_q.data;
    assign all_rdy_o = slot_q.valid && (&slot_q.rdy);

endmodule

// File: rtl/fu_issue_queue.sv
// fu_issue_queue
//   Issue queue in front of a multi-cycle functional unit. Dispatch lanes are
//   written into the lowest free slots, an age matrix orders the entries,
//   and the selected entry moves into a registered valid/ready issue stage.
//   OOO_ISSUE=0 issues only the oldest entry (once it is ready);
//   OOO_ISSUE=1 issues the oldest entry whose operands are all ready.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     flush             synchronous flush of slots, ages and issue stage
//     disp_valid_i      per-lane dispatch request
//     disp_payload_i    per-lane payload
//     disp_data_i       per-lane operand values
//     disp_tag_i        per-lane producer tags
//     disp_rdy_i        per-lane operand-valid bits
//     disp_ready_o      registered: at least DISP_W slots free
//     cdb_valid_i/tag_i/data_i  CDB broadcast ports
//     iss_valid_o       issue register holds an instruction
//     iss_ready_i       functional unit accepts the instruction
//     iss_payload_o     issued payload
//     iss_data_o        issued operands
//     occupancy_o       registered count of occupied slots
module fu_issue_queue
    import iq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DISP_W    = 2,
    parameter int REG_COUNT = IQ_REG_COUNT,
    parameter int CDB_COUNT = IQ_CDB_COUNT,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W,
    parameter int OOO_ISSUE = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    flush,
    input  logic    [DISP_W-1:0]                    disp_valid_i,
    input  logic    [DISP_W-1:0][PAYLOAD_W-1:0]     disp_payload_i,
    input  word_t   [DISP_W-1:0][REG_COUNT-1:0]     disp_data_i,
    input  rob_id_t [DISP_W-1:0][REG_COUNT-1:0]     disp_tag_i,
    input  logic    [DISP_W-1:0][REG_COUNT-1:0]     disp_rdy_i,
    output logic                                    disp_ready_o,
    input  logic    [CDB_COUNT-1:0]                 cdb_valid_i,
    input  rob_id_t [CDB_COUNT-1:0]                 cdb_tag_i,
    input  word_t   [CDB_COUNT-1:0]                 cdb_data_i,
    output logic                                    iss_valid_o,
    input  logic                                    iss_ready_i,
    output logic    [PAYLOAD_W-1:0]                 iss_payload_o,
    output word_t   [REG_COUNT-1:0]                 iss_data_o,
    output logic    [$clog2(DEPTH):0]               occupancy_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]            slot_valid;
    logic [DEPTH-1:0]            slot_rdy;
    logic [PAYLOAD_W-1:0]        slot_payload [DEPTH];
    word_t [REG_COUNT-1:0]       slot_data    [DEPTH];

    logic [DEPTH-1:0]            wr_en;
    logic [DEPTH-1:0]            taken;
    iq_slot_t                    wr_slot      [DEPTH];
    logic                        accept;
    logic                        alloc_found;
    logic [CNT_W-1:0]            accept_cnt;

    logic [DEPTH-1:0]            older_q      [DEPTH];
    logic [DEPTH-1:0]            older_d      [DEPTH];

    logic [DEPTH-1:0]            blocked;
    logic [DEPTH-1:0]            cand;
    logic [DEPTH-1:0]            sel_oh;
    logic                        sel_found;
    logic [PAYLOAD_W-1:0]        sel_payload;
    word_t [REG_COUNT-1:0]       sel_data;
    logic                        fire;

    logic                        iss_valid_q;
    logic [PAYLOAD_W-1:0]        iss_payload_q;
    word_t [REG_COUNT-1:0]       iss_data_q;

    logic [CNT_W-1:0]            occ_q;
    logic [CNT_W-1:0]            occ_d;
    logic                        disp_ready_q;
    logic                        disp_ready_d;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        iq_slot u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (flush),
            .wr_en       (wr_en[g]),
            .clr         (sel_oh[g] && fire),
            .wr_slot     (wr_slot[g]),
            .cdb_valid_i (cdb_valid_i),
            .cdb_tag_i   (cdb_tag_i),
            .cdb_data_i  (cdb_data_i),
            .valid_o     (slot_valid[g]),
            .payload_o   (slot_payload[g]),
            .data_o      (slot_data[g]),
            .all_rdy_o   (slot_rdy[g])
        );
    end

    // Allocator: each valid lane, in lane order, takes the lowest slot that
    // is free and not already claimed by an earlier lane. Slots issuing this
    // cycle are still marked valid, so they only become reusable next cycle.
    always_comb begin
        accept      = disp_ready_q && !flush;
        taken       = '0;
        wr_en       = '0;
        accept_cnt  = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_slot[i] = '0;
        end
        for (int l = 0; l < DISP_W; l++) begin
            alloc_found = 1'b0;
            if (accept && disp_valid_i[l]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!alloc_found && !slot_valid[i] && !taken[i]) begin
                        alloc_found        = 1'b1;
                        taken[i]           = 1'b1;
                        wr_en[i]           = 1'b1;
                        wr_slot[i].valid   = 1'b1;
                        wr_slot[i].payload = disp_payload_i[l];
                        wr_slot[i].data    = disp_data_i[l];
                        wr_slot[i].tag     = disp_tag_i[l];
                        wr_slot[i].rdy     = disp_rdy_i[l];
                        accept_cnt         = accept_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Age matrix update. A newly written slot is younger than every occupied
    // slot. Same-cycle writes land in ascending slot order by lane, so among
    // them the lower slot index is the older one. Rows of freed slots go
    // stale but are always masked by slot_valid when read.
    always_comb begin
        older_d = older_q;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (wr_en[i]) begin
                    older_d[i][k] = wr_en[k] && (k > i);
                end else if (wr_en[k]) begin
                    older_d[i][k] = slot_valid[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            older_q <= older_d;
        end
    end

    // Selection. In-order mode: a slot is blocked by any older occupied slot,
    // so only the oldest can go, and only when ready. Out-of-order mode: a
    // ready slot is blocked only by an older ready slot.
    always_comb begin
        blocked = '0;
        cand    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && older_q[j][i] && slot_valid[j] &&
                    ((OOO_ISSUE == 0) || slot_rdy[j])) begin
                    blocked[i] = 1'b1;
                end
            end
            cand[i] = slot_rdy[i] && !blocked[i];
        end
    end

    always_comb begin
        sel_oh      = '0;
        sel_found   = 1'b0;
        sel_payload = '0;
        sel_data    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand[i] && !sel_found) begin
                sel_found   = 1'b1;
                sel_oh[i]   = 1'b1;
                sel_payload = slot_payload[i];
                sel_data    = slot_data[i];
            end
        end
    end

    assign fire = sel_found && (!iss_valid_q || iss_ready_i) && !flush;

    // Issue register: flush beats any handshake in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q   <= 1'b0;
            iss_payload_q <= '0;
            iss_data_q    <= '0;
        end else if (flush) begin
            iss_valid_q   <= 1'b0;
            iss_payload_q <= '0;
            iss_data_q    <= '0;
        end else if (fire) begin
            iss_valid_q   <= 1'b1;
            iss_payload_q <= sel_payload;
            iss_data_q    <= sel_data;
        end else if (iss_ready_i) begin
            iss_valid_q   <= 1'b0;
        end
    end

    assign occ_d        = occ_q + accept_cnt - CNT_W'(fire);
    assign disp_ready_d = (int'(occ_d) + DISP_W) <= DEPTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q        <= '0;
            disp_ready_q <= 1'b1;
        end else if (flush) begin
            occ_q        <= '0;
            disp_ready_q <= 1'b1;
        end else begin
            occ_q        <= occ_d;
            disp_ready_q <= disp_ready_d;
        end
    end

    assign disp_ready_o  = disp_ready_q;
    assign occupancy_o   = occ_q;
    assign iss_valid_o   = iss_valid_q;
    assign iss_payload_o = iss_payload_q;
    assign iss_data_o    = iss_data_q;

endmodule
